jpeg_block_fetch: RTL and testbench

- Sequencer in front of the JPEG pipeline.
- On start, reads a raster 8-bit greyscale image from pixel memory and reorders it into 8x8 blocks: 64 pixels row-major per block, blocks left-to-right then top-to-bottom.
- Streams the pixels into the pipeline's pixel input under its ready/enable handshake.
- After the last pixel it signals end of image, waits for the pipeline's flush-complete, then reports done.

---
 rtl/jpeg_pkg.sv | 15 +
 rtl/jpeg_pix_fifo.sv | 55 +++++
 rtl/jpeg_block_fetch.sv | 221 ++++++++++++++++++++++
 tb/tb_jpeg_block_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG block-fetch front end.
package jpeg_pkg;

  localparam int BLK_DIM = 8;   // pixels per block edge
  localparam int BLK_PIX = 64;  // pixels per 8x8 block

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/jpeg_pix_fifo.sv
// Small synchronous FIFO buffering pixel read data ahead of the pipeline.
// dout shows the head entry whenever the FIFO is non-empty.
module jpeg_pix_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array write.
  // NOTE: the data array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; push and pop in one cycle are both honoured.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_block_fetch.sv
// Reads a raster greyscale frame from pixel memory in 8x8 block order and
// streams it into the JPEG pipeline, then handles end-of-image and flush.
module jpeg_block_fetch
  import jpeg_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DIM_W      = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [DIM_W-1:0]     width_blk,
  input  logic [DIM_W-1:0]     height_blk,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic                 mem_waitrequest,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_rvalid,
  output logic [7:0]           pix_out,
  output logic                 pix_ena,
  input  logic                 pix_rdy,
  output logic                 done_image,
  input  logic                 done_block,
  input  logic                 done_flush,
  output logic                 busy,
  output logic                 done,
  output logic [2*DIM_W-1:0]   blocks_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state, state_nxt;

  // Latched frame configuration.
  logic [DIM_W-1:0]  cfg_w;
  logic [DIM_W-1:0]  cfg_h;
  logic              cfg_empty;     // zero-sized frame: no reads, no end-of-image
  logic [ADDR_W-1:0] stride;        // bytes per image line
  logic [ADDR_W-1:0] stride8;       // bytes per band of 8 lines

  // Scan position and incrementally maintained addresses.
  logic [2:0]        col;
  logic [2:0]        row;
  logic [DIM_W-1:0]  bx;
  logic [DIM_W-1:0]  by;
  logic [ADDR_W-1:0] addr_q;        // current request address
  logic [ADDR_W-1:0] line_q;        // first pixel of current block row
  logic [ADDR_W-1:0] blk_q;         // top-left pixel of current block
  logic [ADDR_W-1:0] band_q;        // top-left pixel of current block band

  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic              fifo_empty;
  logic [7:0]        fifo_dout;

  logic              start_ok;
  logic              credit_ok;
  logic              accept;
  logic              rsp_ok;
  logic              last_req;
  logic              pop;

  assign start_ok  = (state == ST_IDLE) && start;
  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok = inflight < (CNT_W+1)'(FIFO_DEPTH);
  assign accept    = mem_rd && !mem_waitrequest;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign rsp_ok    = mem_rvalid && (outstanding != '0);
  assign last_req  = (col == 3'd7) && (row == 3'd7) &&
                     (bx == cfg_w - DIM_W'(1)) && (by == cfg_h - DIM_W'(1));
  assign mem_addr  = addr_q;
  assign pix_ena   = !fifo_empty;
  assign pix_out   = fifo_empty ? 8'h00 : fifo_dout;
  assign pop       = pix_ena && pix_rdy;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control outputs.
  // NOTE: every output is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    done_image = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // Empty frames pass through DRAIN so busy is visible for one cycle.
          state_nxt = (width_blk == '0 || height_blk == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy   = 1'b1;
        mem_rd = credit_ok;
        if (credit_ok && !mem_waitrequest && last_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (outstanding == '0 && fifo_empty) begin
          done_image = !cfg_empty;
          state_nxt  = cfg_empty ? ST_DONE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (done_flush) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration latch and block-order address walk (adders only, no multiply).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_w     <= '0;
      cfg_h     <= '0;
      cfg_empty <= 1'b0;
      stride    <= '0;
      stride8   <= '0;
      col       <= '0;
      row       <= '0;
      bx        <= '0;
      by        <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      blk_q     <= '0;
      band_q    <= '0;
    end else if (start_ok) begin
      cfg_w     <= width_blk;
      cfg_h     <= height_blk;
      cfg_empty <= (width_blk == '0) || (height_blk == '0);
      stride    <= ADDR_W'({width_blk, 3'b000});
      stride8   <= ADDR_W'({width_blk, 6'b000000});
      col       <= '0;
      row       <= '0;
      bx        <= '0;
      by        <= '0;
      addr_q    <= base_addr;
      line_q    <= base_addr;
      blk_q     <= base_addr;
      band_q    <= base_addr;
    end else if (accept) begin
      if (col != 3'd7) begin
        col    <= col + 3'd1;
        addr_q <= addr_q + ADDR_W'(1);
      end else if (row != 3'd7) begin
        col    <= '0;
        row    <= row + 3'd1;
        line_q <= line_q + stride;
        addr_q <= line_q + stride;
      end else if (bx != cfg_w - DIM_W'(1)) begin
        col    <= '0;
        row    <= '0;
        bx     <= bx + DIM_W'(1);
        blk_q  <= blk_q + ADDR_W'(BLK_DIM);
        line_q <= blk_q + ADDR_W'(BLK_DIM);
        addr_q <= blk_q + ADDR_W'(BLK_DIM);
      end else if (by != cfg_h - DIM_W'(1)) begin
        col    <= '0;
        row    <= '0;
        bx     <= '0;
        by     <= by + DIM_W'(1);
        band_q <= band_q + stride8;
        blk_q  <= band_q + stride8;
        line_q <= band_q + stride8;
        addr_q <= band_q + stride8;
      end
    end
  end

  // Outstanding-read count: +1 per accepted request, -1 per response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, rsp_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Saturating per-frame count of pipeline block completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_done <= '0;
    end else if (start_ok) begin
      blocks_done <= '0;
    end else if (done_block && state != ST_IDLE && blocks_done != '1) begin
      blocks_done <= blocks_done + (2*DIM_W)'(1);
    end
  end

  jpeg_pix_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_ok),
    .pop   (pop),
    .din   (mem_rdata),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_jpeg_block_fetch.sv
// Directed bench for jpeg_block_fetch: block-order address/pixel stream,
// handshake back-pressure, empty frame, mid-frame reset, ignored inputs.
module tb_jpeg_block_fetch;

  localparam int ADDR_W     = 24;
  localparam int DIM_W      = 7;
  localparam int FIFO_DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [DIM_W-1:0]    width_blk = '0;
  logic [DIM_W-1:0]    height_blk = '0;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic                mem_waitrequest = 1'b0;
  logic [7:0]          mem_rdata = '0;
  logic                mem_rvalid = 1'b0;
  logic [7:0]          pix_out;
  logic                pix_ena;
  logic                pix_rdy = 1'b0;
  logic                done_image;
  logic                done_block = 1'b0;
  logic                done_flush = 1'b0;
  logic                busy;
  logic                done;
  logic [2*DIM_W-1:0]  blocks_done;

  always #5 clk = ~clk;

  jpeg_block_fetch #(
    .ADDR_W     (ADDR_W),
    .DIM_W      (DIM_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .width_blk       (width_blk),
    .height_blk      (height_blk),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_waitrequest (mem_waitrequest),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .pix_out         (pix_out),
    .pix_ena         (pix_ena),
    .pix_rdy         (pix_rdy),
    .done_image      (done_image),
    .done_block      (done_block),
    .done_flush      (done_flush),
    .busy            (busy),
    .done            (done),
    .blocks_done     (blocks_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0, fcyc = 0;
  int n_req = 0, n_pix = 0, last_xfer_cyc = 0;
  int di_cnt = 0, di_cyc = 0, done_cnt = 0, rd_cycles = 0, stale_left = 0;
  int w_cfg = 2;
  logic [ADDR_W-1:0] base_cfg = 24'h001000;
  logic              resp_pending = 1'b0;
  logic [7:0]        resp_data = '0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              rdy_mode = 1'b0, wait_mode = 1'b0, inject = 1'b0, blk_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference address of the k-th pixel in block order.
  function automatic logic [ADDR_W-1:0] exp_addr(input int k);
    int b, bx, by, r, c;
    b  = k / 64;
    bx = b % w_cfg;
    by = b / w_cfg;
    r  = (k % 64) / 8;
    c  = k % 8;
    return base_cfg + ADDR_W'((by * 8 + r) * w_cfg * 8 + bx * 8 + c);
  endfunction

  // One clock: drive inputs at the falling edge, then observe the DUT.
  task automatic cycle();
    logic [ADDR_W-1:0] ea;
    logic [7:0]        ep;
    int                occ;
    @(negedge clk);
    cyc++;
    fcyc++;
    if (stale_left > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'hAA;
      stale_left--;
    end else begin
      mem_rvalid = resp_pending;
      mem_rdata  = resp_pending ? resp_data : 8'h00;
    end
    pix_rdy         = rdy_mode ? (cyc % 3 == 0) : 1'b1;
    mem_waitrequest = wait_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (inject && fcyc == 10) begin
      start = 1'b1; done_flush = 1'b1; base_addr = 24'h005555; width_blk = 7'd3;
    end else if (inject && fcyc == 11) begin
      start = 1'b0; done_flush = 1'b0; base_addr = base_cfg; width_blk = 7'd2;
    end
    if (blk_mode) done_block = (fcyc == 20 || fcyc == 40);

    if (prev_stall) begin
      check("addr_hold", mem_addr, prev_addr);
      check("rd_hold", mem_rd, 1);
    end
    occ = n_req - n_pix;
    check("credit", occ <= FIFO_DEPTH, 1);
    if (mem_rd) rd_cycles++;
    resp_pending = mem_rd && !mem_waitrequest;
    if (resp_pending) begin
      ea = exp_addr(n_req);
      check("req_addr", mem_addr, ea);
      resp_data = mem_addr[7:0];
      n_req++;
    end
    prev_stall = mem_rd && mem_waitrequest;
    prev_addr  = mem_addr;
    if (pix_ena && pix_rdy) begin
      ea = exp_addr(n_pix);
      ep = ea[7:0];
      check("pixel", pix_out, ep);
      n_pix++;
      last_xfer_cyc = cyc;
    end
    if (done_image) begin
      di_cnt++;
      di_cyc = cyc;
    end
    if (done) done_cnt++;
  endtask

  // Full 2x1-block frame at 0x1000 with optional back-pressure and side pulses.
  task automatic run_frame(input logic rdy_m, input logic wait_m, input logic inj, input logic blk);
    w_cfg = 2; base_cfg = 24'h001000;
    base_addr = base_cfg; width_blk = 7'd2; height_blk = 7'd1;
    n_req = 0; n_pix = 0; di_cnt = 0; done_cnt = 0; fcyc = 0;
    rdy_mode = rdy_m; wait_mode = wait_m; inject = inj; blk_mode = blk;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("busy_start", busy, 1);
    for (int i = 0; i < 4000 && di_cnt == 0; i++) cycle();
    check("frame_end", di_cnt, 1);
    check("pix_count", n_pix, 128);
    check("req_count", n_req, 128);
    check("di_latency", di_cyc, last_xfer_cyc + 1);
    inject = 1'b0; blk_mode = 1'b0; done_block = 1'b0;
    cycle();
    check("flush_busy", busy, 1);
    check("early_done", done_cnt, 0);
    done_flush = 1'b1;
    cycle();
    done_flush = 1'b0;
    check("done_pulse", done, 1);
    check("busy_off", busy, 0);
    if (blk) done_block = 1'b1;
    cycle();
    done_block = 1'b0;
    check("done_once", done_cnt, 1);
    check("di_once", di_cnt, 1);
    if (blk) check("blocks_done", blocks_done, 3);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) cycle();
    check("rst_mem_rd", mem_rd, 0);
    check("rst_pix_ena", pix_ena, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_image", done_image, 0);
    check("rst_blocks", blocks_done, 0);
    check("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    cycle();

    // Plain stream, then back-pressure on both sides.
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);

    // Zero-width frame: busy for one cycle, done pulse, no reads.
    rdy_mode = 1'b0; wait_mode = 1'b0;
    width_blk = 7'd0; height_blk = 7'd5; rd_cycles = 0; di_cnt = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("zero_busy", busy, 1);
    check("zero_done_early", done, 0);
    cycle();
    check("zero_done", done, 1);
    check("zero_busy_off", busy, 0);
    cycle();
    check("zero_done_once", done, 0);
    check("zero_no_rd", rd_cycles, 0);
    check("zero_no_di", di_cnt, 0);

    // Reset in the middle of a frame, then stale responses.
    w_cfg = 2; base_cfg = 24'h001000;
    base_addr = base_cfg; width_blk = 7'd2; height_blk = 7'd1;
    n_req = 0; n_pix = 0; fcyc = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 400 && n_pix < 30; i++) cycle();
    check("mid_pix", n_pix, 30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", mem_rd, 0);
    check("mid_rst_ena", pix_ena, 0);
    check("mid_rst_pix", pix_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_di", done_image, 0);
    resp_pending = 1'b0;
    prev_stall   = 1'b0;
    cycle();
    rst_n = 1'b1;
    stale_left = 3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stale_ena", pix_ena, 0);
      check("stale_rd", mem_rd, 0);
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Start and done_flush during FETCH are ignored.
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Three block completions, the last coinciding with done.
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
